// File: rtl/tagged_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tagged_mem_responder
//  Description : Responder end of the proc2mem/mem2proc tagged memory bus.
//                Grants a 4-bit tag combinationally on every accepted
//                LOAD/STORE. Stores write the backing array at once. Loads
//                return {tag,data} a fixed LATENCY cycles after acceptance,
//                strictly in order.
//                Optional macro TAGGED_MEM_ERR_EN: out-of-range requests are
//                accepted and flagged on mem2proc_err instead of rejected.
//  Revision    : 1.0  initial release
// ============================================================================
module tagged_mem_responder #(
  parameter int MEM_WORDS       = 1024,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] proc2mem_addr,
  input  logic [31:0] proc2mem_data,
  input  logic [1:0]  proc2mem_command,
  output logic [3:0]  mem2proc_response,
  output logic [31:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
`ifdef TAGGED_MEM_ERR_EN
  ,
  output logic        mem2proc_err
`endif
);

  localparam logic [1:0]  BUS_LOAD  = 2'd1;
  localparam logic [1:0]  BUS_STORE = 2'd2;
  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

  // Backing array; never reset, contents are preloaded or written by stores.
  logic [31:0] unified_memory [MEM_WORDS];

  logic [29:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             in_range;
  logic             addr_ok;
  logic             is_load;
  logic             is_store;
  logic             returning;
  logic             load_room;
  logic             accept_load;
  logic             accept_store;
  logic [31:0]      load_word;
  logic [3:0]       tag_ctr;
  logic [3:0]       outstanding;
  logic             unused_addr_bits;

  // Delay line: entry 0 is filled at the acceptance edge, entry LATENCY-1 is
  // the one about to be presented on the output registers.
  logic [LATENCY-1:0]       pipe_vld;
  logic [LATENCY-1:0][3:0]  pipe_tag;
  logic [LATENCY-1:0][31:0] pipe_data;
`ifdef TAGGED_MEM_ERR_EN
  logic [LATENCY-1:0]       pipe_err;
  logic                     store_err_d;
`endif

  // Byte-lane bits carry no meaning on a word-wide bus.
  assign unused_addr_bits = ^proc2mem_addr[1:0];

  assign word_idx  = proc2mem_addr[31:2];
  assign mem_idx   = word_idx[IDX_W-1:0];
  assign in_range  = ({2'b00, word_idx} < 32'(MEM_WORDS));
  assign is_load   = (proc2mem_command == BUS_LOAD);
  assign is_store  = (proc2mem_command == BUS_STORE);
  // A load leaving the delay line frees its slot in the same cycle.
  assign returning = pipe_vld[LATENCY-1];
  assign load_room = (outstanding < 4'(MAX_OUTSTANDING)) || returning;

`ifdef TAGGED_MEM_ERR_EN
  assign addr_ok = 1'b1;
`else
  assign addr_ok = in_range;
`endif

  // Nothing is accepted while reset is held, so no tag is granted then.
  assign accept_load  = rst_n && is_load  && addr_ok && load_room;
  assign accept_store = rst_n && is_store && addr_ok;

  // Grant the current tag combinationally for any accepted command.
  always_comb begin
    mem2proc_response = 4'd0;
    if (accept_load || accept_store) begin
      mem2proc_response = tag_ctr;
    end
  end

  // Array read for an accepted load; out-of-range reads yield the error word.
  always_comb begin
    load_word = ERR_DATA;
    if (in_range) begin
      load_word = unified_memory[mem_idx];
    end
  end

  // Store path: write the array at the acceptance edge, only when in range.
  always_ff @(posedge clk) begin
    if (accept_store && in_range) begin
      unified_memory[mem_idx] <= proc2mem_data;
    end
  end

  // Tag counter cycles 1..15 so that 0 always means "no tag".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_ctr <= 4'd1;
    end else if (accept_load || accept_store) begin
      tag_ctr <= (tag_ctr == 4'd15) ? 4'd1 : tag_ctr + 4'd1;
    end
  end

  // Loads in flight: up on acceptance, down on return, flat when both occur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 4'd0;
    end else begin
      case ({accept_load, returning})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Delay line shift; reset discards every in-flight load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_tag  <= '0;
      pipe_data <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_tag[i]  <= pipe_tag[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
      pipe_vld[0]  <= accept_load;
      pipe_tag[0]  <= accept_load ? tag_ctr : 4'd0;
      pipe_data[0] <= accept_load ? load_word : 32'd0;
    end
  end

  // Return registers: present the exiting entry for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem2proc_tag  <= 4'd0;
      mem2proc_data <= 32'd0;
    end else begin
      mem2proc_tag  <= returning ? pipe_tag[LATENCY-1]  : 4'd0;
      mem2proc_data <= returning ? pipe_data[LATENCY-1] : 32'd0;
    end
  end

`ifdef TAGGED_MEM_ERR_EN
  // Error flags: load errors ride the delay line, store errors flag one cycle
  // after acceptance with no tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_err     <= '0;
      store_err_d  <= 1'b0;
      mem2proc_err <= 1'b0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        pipe_err[i] <= pipe_err[i-1];
      end
      pipe_err[0]  <= accept_load && !in_range;
      store_err_d  <= accept_store && !in_range;
      mem2proc_err <= (returning && pipe_err[LATENCY-1]) || store_err_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tagged_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tagged_mem_responder
//  Description : Directed bench for tagged_mem_responder (LATENCY=4,
//                MAX_OUTSTANDING=2). Expected returns are queued by hand per
//                accepted load and checked every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tagged_mem_responder;

  localparam int         LAT   = 4;
  localparam int         MAXO  = 2;
  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [1:0]  cmd   = NONE;
  logic [3:0]  resp;
  logic [3:0]  rtag;
  logic [31:0] rdata;
`ifdef TAGGED_MEM_ERR_EN
  logic        rerr;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          q_due[$];
  logic [3:0]  q_tag[$];
  logic [31:0] q_data[$];
  logic        q_err[$];

  always #5 clk = ~clk;

  tagged_mem_responder #(
    .MEM_WORDS      (1024),
    .LATENCY        (LAT),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .proc2mem_addr    (addr),
    .proc2mem_data    (wdata),
    .proc2mem_command (cmd),
    .mem2proc_response(resp),
    .mem2proc_data    (rdata),
    .mem2proc_tag     (rtag)
`ifdef TAGGED_MEM_ERR_EN
    ,
    .mem2proc_err     (rerr)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic expect_ret(input int due, input logic [3:0] t, input logic [31:0] d, input logic e);
    q_due.push_back(due);
    q_tag.push_back(t);
    q_data.push_back(d);
    q_err.push_back(e);
  endtask

  // One clock: drive, check the combinational grant, then check the return port.
  task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] exp_resp, input string name);
    cmd   = c;
    addr  = a;
    wdata = d;
    #1;
    check({name, "/resp"}, 32'(resp), 32'(exp_resp));
    @(posedge clk);
    #1;
    cyc++;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      check({name, "/ret_tag"},  32'(rtag), 32'(q_tag[0]));
      check({name, "/ret_data"}, rdata, q_data[0]);
`ifdef TAGGED_MEM_ERR_EN
      check({name, "/ret_err"}, 32'(rerr), 32'(q_err[0]));
`endif
      void'(q_due.pop_front());
      void'(q_tag.pop_front());
      void'(q_data.pop_front());
      void'(q_err.pop_front());
    end else begin
      check({name, "/idle_tag"},  32'(rtag), 32'd0);
      check({name, "/idle_data"}, rdata, 32'd0);
`ifdef TAGGED_MEM_ERR_EN
      check({name, "/idle_err"}, 32'(rerr), 32'd0);
`endif
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] exp_resp,
                      input logic [31:0] exp_data, input string name);
    step(LOAD, a, 32'd0, exp_resp, name);
    if (exp_resp != 4'd0) expect_ret(cyc + LAT, exp_resp, exp_data, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(NONE, 32'd0, 32'd0, 4'd0, "idle");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q_due.delete();
    q_tag.delete();
    q_data.delete();
    q_err.delete();
    step(NONE, 32'd0, 32'd0, 4'd0, "rst");
    step(NONE, 32'd0, 32'd0, 4'd0, "rst");
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held for 3 cycles with a LOAD on the bus: nothing granted.
    for (int i = 0; i < 3; i++) step(LOAD, 32'h14, 32'd0, 4'd0, "t1_rst");
    rst_n = 1'b1;
    // First accepted command after release gets tag 1; preloads word 5.
    step(STORE, 32'h14, 32'h1234_5678, 4'd1, "t1_first");

    // Basic load; also shows the array survives reset.
    do_reset();
    load(32'h14, 4'd1, 32'h1234_5678, "t2_load");
    idle(6);

    // Store then load of the same word on the next cycle.
    do_reset();
    step(STORE, 32'h40, 32'hCAFE_F00D, 4'd1, "t3_store");
    load(32'h40, 4'd2, 32'hCAFE_F00D, "t3_load");
    idle(6);

    // Backpressure at 2 outstanding; a load in a return cycle is accepted.
    do_reset();
    load(32'h14, 4'd1, 32'h1234_5678, "t4_ld0");
    load(32'h14, 4'd2, 32'h1234_5678, "t4_ld1");
    load(32'h14, 4'd0, 32'h0,         "t4_ld2");
    load(32'h14, 4'd0, 32'h0,         "t4_ld3");
    load(32'h14, 4'd3, 32'h1234_5678, "t4_ld_ret");
    idle(6);

    // Tag wrap across 16 stores, then read one back.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(STORE, 32'h200 + 32'(4 * i), 32'(i) + 32'hA500_0000,
           (i < 15) ? 4'(i + 1) : 4'd1, "t5_wrap");
    end
    load(32'h238, 4'd2, 32'hA500_000E, "t5_readback");
    idle(6);

    // Out-of-range requests and the last legal word.
    do_reset();
`ifdef TAGGED_MEM_ERR_EN
    step(STORE, 32'h1000, 32'h5555_5555, 4'd1, "t6_oor_st");
    expect_ret(cyc + 1, 4'd0, 32'd0, 1'b1);
    step(LOAD, 32'h1000, 32'd0, 4'd2, "t6_oor_ld");
    expect_ret(cyc + LAT, 4'd2, 32'hDEAD_BEEF, 1'b1);
    load(32'h14, 4'd3, 32'h1234_5678, "t6_ok_ld");
    idle(6);
`else
    step(STORE, 32'h1000, 32'h5555_5555, 4'd0, "t6_oor_st");
    load(32'h1000, 4'd0, 32'h0, "t6_oor_ld");
    load(32'h14, 4'd1, 32'h1234_5678, "t6_ok_ld");
    step(STORE, 32'hFFC, 32'h0BAD_F00D, 4'd2, "t6_last_st");
    load(32'hFFC, 4'd3, 32'h0BAD_F00D, "t6_last_ld");
    idle(6);
`endif

    // Reset mid-flight: the pending load must never come back.
    do_reset();
    load(32'h14, 4'd1, 32'h1234_5678, "t6_flight");
    idle(2);
    do_reset();
    idle(6);
    load(32'h14, 4'd1, 32'h1234_5678, "t6_after_rst");
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
